mitll_merger_sync: RTL and testbench

Clock-synchronous behavioural model of an RSFQ merger (confluence buffer): two toggle-encoded pulse inputs combine into one toggle-encoded output. It is the fan-in counterpart to the splitter cell and closes split/merge loops in cycle-based cell-library simulation. Input-to-output delay, the critical-timing (hold-off) window, startup masking and violation reporting are expressed in clock cycles.

---
 rtl/mitll_sync_pkg.sv | 21 ++
 rtl/mitll_pulse_delay.sv | 36 +++
 rtl/mitll_merger_sync.sv | 180 ++++++++++++++++++
 tb/tb_mitll_merger_sync.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mitll_sync_pkg.sv
// mitll_sync_pkg
// Shared definitions for the clock-synchronous RSFQ cell models (merger,
// splitter, DFF). It holds the cell state encoding, the default timing
// parameters and the width of the violation counter.
package mitll_sync_pkg;

    // Cell life cycle: settle after reset, wait for a pulse, sit out the
    // critical-timing window, or lock up after a violation (lock mode only).
    typedef enum logic [1:0] {
        STARTUP = 2'd0,
        IDLE    = 2'd1,
        HOLD    = 2'd2,
        ERROR   = 2'd3
    } cell_state_t;

    localparam int DEF_DELAY_CYC   = 4;
    localparam int DEF_HOLDOFF_CYC = 3;
    localparam int DEF_STARTUP_CYC = 4;
    localparam int VIOL_CNT_W      = 8;

endpackage

// File: rtl/mitll_pulse_delay.sv
// mitll_pulse_delay
// DEPTH-stage pulse shift line. A pulse entering at one edge appears at
// pulse_out DEPTH-1 edges later, so a registered consumer sees it DEPTH
// edges after injection. Every stage is independent, which means
// back-to-back pulses are never merged.
// Ports:
//   clk       rising-edge clock
//   clr       synchronous clear of every stage (highest priority)
//   pulse_in  one-cycle pulse to inject
//   pulse_out last stage of the line
module mitll_pulse_delay #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic pulse_in,
    output logic pulse_out
);

    logic [DEPTH-1:0] line;

    // The per-bit loop keeps DEPTH=1 legal without any zero-width slice.
    always_ff @(posedge clk) begin
        if (clr) begin
            line <= '0;
        end else begin
            line[0] <= pulse_in;
            for (int i = 1; i < DEPTH; i++) begin
                line[i] <= line[i-1];
            end
        end
    end

    assign pulse_out = line[DEPTH-1];

endmodule

// File: rtl/mitll_merger_sync.sv
// mitll_merger_sync
// Cycle-based model of an RSFQ merger: two toggle-encoded inputs are merged
// into one toggle-encoded output after DELAY_CYC cycles. After an accepted
// pulse a HOLDOFF_CYC window opens; any pulse inside it is a violation and
// is dropped. Pulses arriving in the first STARTUP_CYC cycles after reset
// are ignored.
// Optional feature macro: MERGER_ERR_LOCK_EN. When it is defined, the first
// violation locks the cell in ERROR (line flushed, out frozen, err sticky)
// until rst. When it is undefined, err is a one-cycle flag per violation.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   in1, in2  toggle-encoded pulse inputs
//   out       toggle-encoded merged output
//   busy      high while the hold-off window is open
//   err       violation indicator
//   viol_cnt  saturating count of violating cycles
module mitll_merger_sync
    import mitll_sync_pkg::*;
#(
    parameter int DELAY_CYC   = DEF_DELAY_CYC,
    parameter int HOLDOFF_CYC = DEF_HOLDOFF_CYC,
    parameter int STARTUP_CYC = DEF_STARTUP_CYC
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in1,
    input  logic                  in2,
    output logic                  out,
    output logic                  busy,
    output logic                  err,
    output logic [VIOL_CNT_W-1:0] viol_cnt
);

    localparam int SW = (STARTUP_CYC < 2) ? 1 : $clog2(STARTUP_CYC);
    localparam int HW = (HOLDOFF_CYC < 2) ? 1 : $clog2(HOLDOFF_CYC + 1);
    localparam cell_state_t RESET_STATE = (STARTUP_CYC == 0) ? IDLE : STARTUP;

    generate
        if (DELAY_CYC < 1 || HOLDOFF_CYC < 0 || STARTUP_CYC < 0) begin : g_param_check
            $error("mitll_merger_sync: DELAY_CYC must be >= 1, HOLDOFF_CYC and STARTUP_CYC >= 0");
        end
    endgenerate

    cell_state_t   state;
    logic [SW-1:0] startup_cnt;
    logic [HW-1:0] hold_cnt;
    logic          in1_q;
    logic          in2_q;
    logic          pulse1;
    logic          pulse2;
    logic          inject;
    logic          viol;
    logic          line_clr;
    logic          line_out;

    // Edge detection on the toggle inputs, plus the decision of what this
    // cycle's pulses do: enter the delay line, count as a violation, or
    // vanish (startup mask, error lock).
    always_comb begin
        pulse1 = in1 ^ in1_q;
        pulse2 = in2 ^ in2_q;
        inject = 1'b0;
        viol   = 1'b0;
        case (state)
            IDLE: begin
                if (pulse1 && pulse2) begin
                    viol = 1'b1;
`ifdef MERGER_ERR_LOCK_EN
                    inject = 1'b0;
`else
                    inject = 1'b1;
`endif
                end else begin
                    inject = pulse1 | pulse2;
                end
            end
            HOLD:    viol = pulse1 | pulse2;
            default: ;
        endcase
    end

`ifdef MERGER_ERR_LOCK_EN
    assign line_clr = rst || (state == ERROR);
`else
    assign line_clr = rst;
`endif

    mitll_pulse_delay #(
        .DEPTH (DELAY_CYC)
    ) u_delay (
        .clk       (clk),
        .clr       (line_clr),
        .pulse_in  (inject),
        .pulse_out (line_out)
    );

    // Cell state machine with registered outputs. in_k_q still follows the
    // inputs during reset, so releasing rst never produces a phantom pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RESET_STATE;
            startup_cnt <= '0;
            hold_cnt    <= '0;
            in1_q       <= in1;
            in2_q       <= in2;
            out         <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
            viol_cnt    <= '0;
        end else begin
            in1_q <= in1;
            in2_q <= in2;
            if (viol && (viol_cnt != '1)) begin
                viol_cnt <= viol_cnt + VIOL_CNT_W'(1);
            end
`ifdef MERGER_ERR_LOCK_EN
            if (state != ERROR) begin
                out <= out ^ line_out;
            end
            if (viol) begin
                err <= 1'b1;
            end
`else
            out <= out ^ line_out;
            err <= viol;
`endif
            case (state)
                STARTUP: begin
                    if (startup_cnt == SW'(STARTUP_CYC - 1)) begin
                        state <= IDLE;
                    end else begin
                        startup_cnt <= startup_cnt + SW'(1);
                    end
                end
                IDLE: begin
`ifdef MERGER_ERR_LOCK_EN
                    if (viol) begin
                        state <= ERROR;
                    end else if (inject && (HOLDOFF_CYC > 0)) begin
                        state    <= HOLD;
                        hold_cnt <= HW'(HOLDOFF_CYC);
                        busy     <= 1'b1;
                    end
`else
                    if (inject && (HOLDOFF_CYC > 0)) begin
                        state    <= HOLD;
                        hold_cnt <= HW'(HOLDOFF_CYC);
                        busy     <= 1'b1;
                    end
`endif
                end
                HOLD: begin
                    // The window runs to completion regardless of late
                    // pulses; they are dropped, never restart it.
`ifdef MERGER_ERR_LOCK_EN
                    if (viol) begin
                        state <= ERROR;
                        busy  <= 1'b0;
                    end else if (hold_cnt == HW'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - HW'(1);
                    end
`else
                    if (hold_cnt == HW'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - HW'(1);
                    end
`endif
                end
                ERROR: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mitll_merger_sync.sv
// tb_mitll_merger_sync
// Self-checking bench for mitll_merger_sync in its default build (error
// lock disabled). The reference model works on absolute edge numbers since
// reset: accepted pulses are scheduled to toggle out DELAY edges later, and
// the hold-off window is the range of edges after the last acceptance.
module tb_mitll_merger_sync;

    localparam int D = 4;
    localparam int H = 3;
    localparam int S = 4;

    logic       clk;
    logic       rst;
    logic       in1;
    logic       in2;
    logic       out;
    logic       busy;
    logic       err;
    logic [7:0] viol_cnt;

    int n_checks;
    int n_fail;

    // Reference model state
    int   e;
    int   last_acc;
    int   pend[$];
    logic prev1;
    logic prev2;
    logic m_out;
    logic m_busy;
    logic m_err;
    int   m_viol;

    mitll_merger_sync #(
        .DELAY_CYC   (D),
        .HOLDOFF_CYC (H),
        .STARTUP_CYC (S)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in1      (in1),
        .in2      (in2),
        .out      (out),
        .busy     (busy),
        .err      (err),
        .viol_cnt (viol_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the model by one rising edge with the given input levels.
    task automatic model_edge(input logic a, input logic b, input logic r);
        logic p1;
        logic p2;
        if (r) begin
            e        = 0;
            last_acc = -1000;
            pend.delete();
            prev1    = a;
            prev2    = b;
            m_out    = 1'b0;
            m_busy   = 1'b0;
            m_err    = 1'b0;
            m_viol   = 0;
            return;
        end
        e++;
        p1    = a ^ prev1;
        p2    = b ^ prev2;
        prev1 = a;
        prev2 = b;
        m_err = 1'b0;
        if (pend.size() > 0 && pend[0] == e) begin
            m_out = ~m_out;
            void'(pend.pop_front());
        end
        if (e > S && (p1 || p2)) begin
            if (e <= last_acc + H) begin
                m_err  = 1'b1;
                m_viol = (m_viol < 255) ? m_viol + 1 : 255;
            end else begin
                pend.push_back(e + D);
                last_acc = e;
                if (p1 && p2) begin
                    m_err  = 1'b1;
                    m_viol = (m_viol < 255) ? m_viol + 1 : 255;
                end
            end
        end
        m_busy = (e >= last_acc) && (e < last_acc + H);
    endtask

    // Drive one cycle of stimulus at the falling edge, update the model at
    // the rising edge and return 1 time unit later for sampling.
    task automatic tick(input logic a, input logic b, input logic r);
        @(negedge clk);
        in1 = a;
        in2 = b;
        rst = r;
        @(posedge clk);
        model_edge(a, b, r);
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
            n_checks++;
            if (out !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || viol_cnt !== 8'd0) begin
                n_fail++;
                $display("[TB] FAIL reset cycle %0d: out/busy/err/viol=%b/%b/%b/%0d required 0/0/0/0",
                         c, out, busy, err, viol_cnt);
            end
        end
    endtask

    task automatic test_startup_mask();
        logic a;
        logic b;
        a = in1;
        b = in2;
        tick(a, b, 1'b1);
        for (int c = 1; c <= 12; c++) begin
            if (c == 2 || c == 4 || c == 6) a = ~a;
            if (c == 4) b = ~b;
            tick(a, b, 1'b0);
            n_checks++;
            if (out !== m_out || busy !== m_busy || err !== m_err || viol_cnt !== 8'(m_viol)) begin
                n_fail++;
                $display("[TB] FAIL startup cycle %0d: out/busy/err/viol=%b/%b/%b/%0d required %b/%b/%b/%0d",
                         c, out, busy, err, viol_cnt, m_out, m_busy, m_err, m_viol);
            end
            if (c == 10) begin
                n_checks++;
                if (out !== 1'b1) begin
                    n_fail++;
                    $display("[TB] FAIL startup_out10: out=%b required 1", out);
                end
            end
        end
    endtask

    task automatic test_alternating();
        logic a;
        logic b;
        a = in1;
        b = in2;
        tick(a, b, 1'b1);
        for (int c = 1; c <= 20; c++) begin
            if (c == 10) a = ~a;
            if (c == 14) b = ~b;
            tick(a, b, 1'b0);
            n_checks++;
            if (out !== m_out || busy !== m_busy || err !== 1'b0 || viol_cnt !== 8'(m_viol)) begin
                n_fail++;
                $display("[TB] FAIL alternating cycle %0d: out/busy/err/viol=%b/%b/%b/%0d required %b/%b/0/%0d",
                         c, out, busy, err, viol_cnt, m_out, m_busy, m_viol);
            end
        end
    endtask

    task automatic test_holdoff_violation();
        logic a;
        logic b;
        a = in1;
        b = in2;
        tick(a, b, 1'b1);
        for (int c = 1; c <= 20; c++) begin
            if (c == 10) a = ~a;
            if (c == 12) b = ~b;
            tick(a, b, 1'b0);
            n_checks++;
            if (out !== m_out || busy !== m_busy || err !== m_err || viol_cnt !== 8'(m_viol)) begin
                n_fail++;
                $display("[TB] FAIL holdoff cycle %0d: out/busy/err/viol=%b/%b/%b/%0d required %b/%b/%b/%0d",
                         c, out, busy, err, viol_cnt, m_out, m_busy, m_err, m_viol);
            end
        end
        n_checks++;
        if (viol_cnt !== 8'd1 || out !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL holdoff_final: viol=%0d out=%b required viol=1 out=1", viol_cnt, out);
        end
    endtask

    task automatic test_coincidence();
        logic a;
        logic b;
        a = in1;
        b = in2;
        tick(a, b, 1'b1);
        for (int c = 1; c <= 20; c++) begin
            if (c == 10) begin
                a = ~a;
                b = ~b;
            end
            tick(a, b, 1'b0);
            n_checks++;
            if (out !== m_out || busy !== m_busy || err !== m_err || viol_cnt !== 8'(m_viol)) begin
                n_fail++;
                $display("[TB] FAIL coincidence cycle %0d: out/busy/err/viol=%b/%b/%b/%0d required %b/%b/%b/%0d",
                         c, out, busy, err, viol_cnt, m_out, m_busy, m_err, m_viol);
            end
        end
        n_checks++;
        if (viol_cnt !== 8'd1 || out !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL coincidence_final: viol=%0d out=%b required viol=1 out=1", viol_cnt, out);
        end
    endtask

    task automatic test_reset_midflight();
        logic a;
        logic b;
        a = in1;
        b = in2;
        tick(a, b, 1'b1);
        for (int c = 1; c <= 20; c++) begin
            if (c == 10) a = ~a;
            tick(a, b, (c == 12) ? 1'b1 : 1'b0);
            n_checks++;
            if (out !== m_out || busy !== m_busy || err !== m_err || viol_cnt !== 8'(m_viol)) begin
                n_fail++;
                $display("[TB] FAIL midflight cycle %0d: out/busy/err/viol=%b/%b/%b/%0d required %b/%b/%b/%0d",
                         c, out, busy, err, viol_cnt, m_out, m_busy, m_err, m_viol);
            end
        end
        n_checks++;
        if (out !== 1'b0 || viol_cnt !== 8'd0) begin
            n_fail++;
            $display("[TB] FAIL midflight_final: out=%b viol=%0d required out=0 viol=0", out, viol_cnt);
        end
    endtask

    task automatic test_random();
        logic a;
        logic b;
        a = in1;
        b = in2;
        tick(a, b, 1'b1);
        for (int c = 1; c <= 400; c++) begin
            if ($urandom_range(0, 4) == 0) a = ~a;
            if ($urandom_range(0, 4) == 0) b = ~b;
            tick(a, b, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
            n_checks++;
            if (out !== m_out || busy !== m_busy || err !== m_err || viol_cnt !== 8'(m_viol)) begin
                n_fail++;
                $display("[TB] FAIL random cycle %0d: out/busy/err/viol=%b/%b/%b/%0d required %b/%b/%b/%0d",
                         c, out, busy, err, viol_cnt, m_out, m_busy, m_err, m_viol);
            end
        end
    endtask

    task automatic test_saturation();
        logic a;
        logic b;
        a = in1;
        b = in2;
        tick(a, b, 1'b1);
        for (int c = 1; c <= 408; c++) begin
            if (c >= 5) begin
                if ((c - 5) % 4 == 0) a = ~a;
                else b = ~b;
            end
            tick(a, b, 1'b0);
            n_checks++;
            if (out !== m_out || busy !== m_busy || err !== m_err || viol_cnt !== 8'(m_viol)) begin
                n_fail++;
                $display("[TB] FAIL saturation cycle %0d: out/busy/err/viol=%b/%b/%b/%0d required %b/%b/%b/%0d",
                         c, out, busy, err, viol_cnt, m_out, m_busy, m_err, m_viol);
            end
        end
        n_checks++;
        if (viol_cnt !== 8'd255) begin
            n_fail++;
            $display("[TB] FAIL saturation_final: viol=%0d required 255", viol_cnt);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        in1      = 1'b0;
        in2      = 1'b0;
        model_edge(1'b0, 1'b0, 1'b1);
        test_reset();
        test_startup_mask();
        test_alternating();
        test_holdoff_violation();
        test_coincidence();
        test_reset_midflight();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
